// File: rtl/pipe_adder_pkg.sv
// -----------------------------------------------------------------------------
// pipe_adder_pkg
//   Shared defaults for the pipelined wide adder and its helper blocks.
//   - DEF_W : default slice width (bits added per pipeline stage)
//   - DEF_N : default number of slices (pipeline stages)
//   - DEF_H : default depth of a delay line when used stand-alone
// -----------------------------------------------------------------------------
package pipe_adder_pkg;

    localparam int DEF_W = 32;
    localparam int DEF_N = 4;
    localparam int DEF_H = 1;

endpackage : pipe_adder_pkg

// File: rtl/pipe_adder_slice.sv
// -----------------------------------------------------------------------------
// pipe_add_slice
//   One stage of the pipelined adder: a W-bit add with carry-in, with the
//   sum and carry-out captured in registers.
// Ports
//   i_clk    in  1  clock, rising edge
//   i_reset  in  1  synchronous active-high reset
//   i_a      in  W  slice of operand A (already skewed)
//   i_b      in  W  slice of operand B (already skewed)
//   i_cin    in  1  carry from the previous stage (or the external cin)
//   o_sum    out W  registered slice sum
//   o_cout   out 1  registered carry out of this slice
// -----------------------------------------------------------------------------
module pipe_add_slice
    import pipe_adder_pkg::*;
#(
    parameter int W = DEF_W
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    input  logic         i_cin,
    output logic [W-1:0] o_sum,
    output logic         o_cout
);

    logic [W:0] w_total;
    logic [W:0] r_total;

    // W+1-bit add so the top bit is the carry out of this slice.
    always_comb begin
        w_total = {1'b0, i_a} + {1'b0, i_b} + {{W{1'b0}}, i_cin};
    end

    // Capture sum and carry together so they stay aligned.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_total <= '0;
        end else begin
            r_total <= w_total;
        end
    end

    assign o_sum  = r_total[W-1:0];
    assign o_cout = r_total[W];

endmodule : pipe_add_slice

// File: rtl/pipe_mem.sv
// -----------------------------------------------------------------------------
// pipe_mem
//   Parameterised delay line: i_d appears on o_q exactly H clock edges later.
//   Every stage clears on a synchronous reset. H must be at least 1; callers
//   that need a zero-length delay bypass the instance in their generate.
// Ports
//   i_clk    in  1  clock, rising edge
//   i_reset  in  1  synchronous active-high reset
//   i_d      in  W  data entering the line
//   o_q      out W  data leaving the line (registered)
// -----------------------------------------------------------------------------
module pipe_mem
    import pipe_adder_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int H = DEF_H
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [W-1:0] i_d,
    output logic [W-1:0] o_q
);

    logic [W-1:0] r_stage [H];

    // Shift register: stage 0 takes the input, each later stage takes its predecessor.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            for (int i = 0; i < H; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int i = 1; i < H; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[H-1];

endmodule : pipe_mem

// File: rtl/pipe_adder.sv
// -----------------------------------------------------------------------------
// pipe_adder
//   Pipelined wide adder: {cout, sum} = a + b + cin over N slices of W bits.
//   Stage k adds slice k one cycle after stage k-1, using the carry that
//   stage k-1 registered. Operand slice k is delayed k cycles on the way in
//   and sum slice k is delayed N-1-k cycles on the way out, so every slice of
//   one operation leaves together, N cycles after it was accepted.
//   Data registers load every cycle; a separate N-bit valid chain marks which
//   outputs belong to real operations. Reset clears everything, so no
//   operation in flight at reset can ever be flagged valid.
// Ports
//   clk        in  1    clock, rising edge
//   reset      in  1    synchronous active-high reset
//   a, b       in  N*W  operands, slice k = [k*W +: W]
//   cin        in  1    carry into slice 0
//   in_valid   in  1    a/b/cin hold a real operation this cycle
//   sum        out N*W  (a + b + cin) mod 2^(N*W)
//   cout       out 1    carry out of slice N-1
//   out_valid  out 1    sum/cout belong to a real operation
// -----------------------------------------------------------------------------
module pipe_adder
    import pipe_adder_pkg::*;
#(
    parameter int W = DEF_W,
    parameter int N = DEF_N
) (
    input  logic           clk,
    input  logic           reset,
    input  logic [N*W-1:0] a,
    input  logic [N*W-1:0] b,
    input  logic           cin,
    input  logic           in_valid,
    output logic [N*W-1:0] sum,
    output logic           cout,
    output logic           out_valid
);

    logic [W-1:0]   w_a_skew [N];
    logic [W-1:0]   w_b_skew [N];
    logic [W-1:0]   w_s      [N];
    logic [N:0]     w_carry;
    logic [N*W-1:0] w_sum_out;
    logic [N-1:0]   r_valid;

    assign w_carry[0] = cin;

    for (genvar k = 0; k < N; k++) begin : g_stage
        // Input skew: slice k meets its carry k cycles after acceptance.
        if (k == 0) begin : g_no_skew
            assign w_a_skew[k] = a[k*W +: W];
            assign w_b_skew[k] = b[k*W +: W];
        end else begin : g_skew
            pipe_mem #(.W(2*W), .H(k)) u_skew (
                .i_clk   (clk),
                .i_reset (reset),
                .i_d     ({a[k*W +: W], b[k*W +: W]}),
                .o_q     ({w_a_skew[k], w_b_skew[k]})
            );
        end

        pipe_add_slice #(.W(W)) u_slice (
            .i_clk   (clk),
            .i_reset (reset),
            .i_a     (w_a_skew[k]),
            .i_b     (w_b_skew[k]),
            .i_cin   (w_carry[k]),
            .o_sum   (w_s[k]),
            .o_cout  (w_carry[k+1])
        );

        // Output deskew: earlier slices wait for the last stage to finish.
        if (k == N-1) begin : g_no_deskew
            assign w_sum_out[k*W +: W] = w_s[k];
        end else begin : g_deskew
            pipe_mem #(.W(W), .H(N-1-k)) u_deskew (
                .i_clk   (clk),
                .i_reset (reset),
                .i_d     (w_s[k]),
                .o_q     (w_sum_out[k*W +: W])
            );
        end
    end

    // Valid chain: one bit per stage, tracking the operation's progress.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            r_valid[0] <= in_valid;
            for (int i = 1; i < N; i++) begin
                r_valid[i] <= r_valid[i-1];
            end
        end
    end

    // The last stage's carry register is aligned with its sum register.
    assign sum       = w_sum_out;
    assign cout      = w_carry[N];
    assign out_valid = r_valid[N-1];

endmodule : pipe_adder

// File: tb/tb_pipe_adder.sv
// -----------------------------------------------------------------------------
// tb_pipe_adder
//   Drives a 4x32 instance and a 1x128 instance with identical stimulus.
//   Expected results are pushed to a per-instance queue at issue time,
//   tagged with the cycle they must appear, and compared by a monitor.
// -----------------------------------------------------------------------------
module tb_pipe_adder;

    typedef struct {
        int           due;
        logic [127:0] s;
        logic         c;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [127:0] a;
    logic [127:0] b;
    logic         cin;
    logic         in_valid;
    logic [127:0] sum4;
    logic         cout4;
    logic         out_valid4;
    logic [127:0] sum1;
    logic         cout1;
    logic         out_valid1;

    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    logic armed = 1'b0;
    exp_t q4[$];
    exp_t q1[$];

    pipe_adder #(.W(32), .N(4)) u_dut4 (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum4),
        .cout      (cout4),
        .out_valid (out_valid4)
    );

    pipe_adder #(.W(128), .N(1)) u_dut1 (
        .clk       (clk),
        .reset     (reset),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .in_valid  (in_valid),
        .sum       (sum1),
        .cout      (cout1),
        .out_valid (out_valid1)
    );

    always #10 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard for the 4-stage instance.
    always @(negedge clk) begin : mon4
        logic exp_v;
        exp_t e;
        if (armed) begin
            exp_v = (q4.size() > 0) && (q4[0].due == cyc);
            total++;
            if (out_valid4 !== exp_v) begin
                bad++;
                $display("FAIL valid_n4 cyc=%0d got=%b want=%b", cyc, out_valid4, exp_v);
            end
            if (exp_v) begin
                e = q4.pop_front();
                total++;
                if (sum4 !== e.s || cout4 !== e.c) begin
                    bad++;
                    $display("FAIL result_n4 cyc=%0d got=%h/%b want=%h/%b", cyc, sum4, cout4, e.s, e.c);
                end
            end
        end
    end

    // Scoreboard for the single-stage instance.
    always @(negedge clk) begin : mon1
        logic exp_v;
        exp_t e;
        if (armed) begin
            exp_v = (q1.size() > 0) && (q1[0].due == cyc);
            total++;
            if (out_valid1 !== exp_v) begin
                bad++;
                $display("FAIL valid_n1 cyc=%0d got=%b want=%b", cyc, out_valid1, exp_v);
            end
            if (exp_v) begin
                e = q1.pop_front();
                total++;
                if (sum1 !== e.s || cout1 !== e.c) begin
                    bad++;
                    $display("FAIL result_n1 cyc=%0d got=%h/%b want=%h/%b", cyc, sum1, cout1, e.s, e.c);
                end
            end
        end
    end

    // Drive one cycle of stimulus, record expectations, advance past the edge.
    task automatic step(input logic r, input logic v, input logic [127:0] av,
                        input logic [127:0] bv, input logic c);
        logic [128:0] t;
        exp_t         e;
        reset    = r;
        in_valid = v;
        a        = av;
        b        = bv;
        cin      = c;
        if (r) begin
            q4.delete();
            q1.delete();
        end else if (v) begin
            t = {1'b0, av} + {1'b0, bv} + {128'd0, c};
            e.s = t[127:0];
            e.c = t[128];
            e.due = cyc + 4;
            q4.push_back(e);
            e.due = cyc + 1;
            q1.push_back(e);
        end
        @(negedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 128'd0, 128'd0, 1'b0);
    endtask

    task automatic test_reset;
        step(1'b1, 1'b0, 128'd0, 128'd0, 1'b0);
        armed = 1'b1;
        for (int i = 0; i < 6; i++) begin
            total++;
            if (sum4 !== 128'd0 || cout4 !== 1'b0 || out_valid4 !== 1'b0 ||
                sum1 !== 128'd0 || cout1 !== 1'b0 || out_valid1 !== 1'b0) begin
                bad++;
                $display("FAIL reset_idle i=%0d got=%h/%b/%b want=0/0/0", i, sum4, cout4, out_valid4);
            end
            step(1'b0, 1'b0, 128'd0, 128'd0, 1'b0);
        end
    endtask

    task automatic test_carry_ripple;
        step(1'b0, 1'b1, {128{1'b1}}, 128'd1, 1'b0);
        idle(3);
        total++;
        if (sum4 !== 128'd0 || cout4 !== 1'b1 || out_valid4 !== 1'b1) begin
            bad++;
            $display("FAIL carry_ripple got=%h/%b/%b want=0/1/1", sum4, cout4, out_valid4);
        end
        idle(2);
    endtask

    task automatic test_patterns;
        step(1'b0, 1'b1, {4{32'hAAAAAAAA}}, {4{32'h55555555}}, 1'b1);
        step(1'b0, 1'b1, 128'h0000FFFF, 128'h00000001, 1'b0);
        idle(2);
        total++;
        if (sum4 !== 128'd0 || cout4 !== 1'b1) begin
            bad++;
            $display("FAIL alt_bits got=%h/%b want=0/1", sum4, cout4);
        end
        idle(1);
        total++;
        if (sum4 !== 128'h00010000 || cout4 !== 1'b0) begin
            bad++;
            $display("FAIL small_carry got=%h/%b want=10000/0", sum4, cout4);
        end
        idle(2);
    endtask

    task automatic test_back_to_back;
        step(1'b0, 1'b1, 128'd1, 128'd2, 1'b0);
        step(1'b0, 1'b1, 128'd3, 128'd4, 1'b0);
        step(1'b0, 1'b1, 128'd5, 128'd6, 1'b0);
        step(1'b0, 1'b1, 128'h8000_0000_0000_0000_0000_0000_0000_0000,
                         128'h8000_0000_0000_0000_0000_0000_0000_0000, 1'b0);
        total++;
        if (sum4 !== 128'd3 || out_valid4 !== 1'b1) begin
            bad++;
            $display("FAIL b2b_first got=%h/%b want=3/1", sum4, out_valid4);
        end
        idle(5);
    endtask

    task automatic test_bubbles;
        logic [4:0] pat;
        int         seen;
        pat = 5'b01101;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, pat[i], {$urandom, $urandom, $urandom, $urandom},
                 {$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1, 0)));
        end
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (out_valid4 === 1'b1) seen++;
            idle(1);
        end
        total++;
        if (seen != 2) begin
            bad++;
            $display("FAIL bubble_count got=%0d want=2", seen);
        end
    endtask

    task automatic test_flush;
        int lat;
        step(1'b0, 1'b1, 128'd10, 128'd20, 1'b0);
        step(1'b0, 1'b1, 128'd30, 128'd40, 1'b1);
        step(1'b0, 1'b1, 128'd50, 128'd60, 1'b0);
        step(1'b1, 1'b1, 128'd70, 128'd80, 1'b0);
        total++;
        if (out_valid4 !== 1'b0 || sum4 !== 128'd0 || cout4 !== 1'b0 ||
            out_valid1 !== 1'b0 || sum1 !== 128'd0) begin
            bad++;
            $display("FAIL flush_clear got=%h/%b/%b want=0/0/0", sum4, cout4, out_valid4);
        end
        step(1'b0, 1'b1, 128'd7, 128'd9, 1'b1);
        total++;
        if (out_valid1 !== 1'b1 || sum1 !== 128'd17) begin
            bad++;
            $display("FAIL flush_n1_lat got=%h/%b want=11/1", sum1, out_valid1);
        end
        lat = 1;
        while (out_valid4 !== 1'b1 && lat < 10) begin
            idle(1);
            lat++;
        end
        total++;
        if (lat != 4) begin
            bad++;
            $display("FAIL flush_n4_lat got=%0d want=4", lat);
        end
        idle(3);
    endtask

    task automatic test_drain;
        int n;
        n = 0;
        while ((q4.size() != 0 || q1.size() != 0) && n < 10) begin
            idle(1);
            n++;
        end
        total++;
        if (q4.size() != 0 || q1.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d/%0d want=0/0", q4.size(), q1.size());
        end
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        a        = 128'd0;
        b        = 128'd0;
        cin      = 1'b0;
        @(negedge clk);
        #2;
        test_reset();
        test_carry_ripple();
        test_patterns();
        test_back_to_back();
        test_bubbles();
        test_flush();
        test_drain();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_pipe_adder
